// File: rtl/agc_gain_controller.sv
// agc_gain_controller
// Closed-loop automatic gain control. The block owns the gain word and runs
// repeated detect windows on the RF-level indicator. After each window it steps
// the gain up or down, or holds it. Every gain change is followed by a settle
// period. The loop locks when the preamble detector raises done, when enough
// consecutive windows land in band, or when the adjust-step budget runs out.
module agc_gain_controller #(
  parameter int CNT_W     = 4,
  parameter int GAIN_W    = 5,
  parameter int GAIN_INIT = 16,
  parameter int GAIN_MIN  = 0,
  parameter int GAIN_MAX  = 31,
  parameter int GOOD_WINS = 2,
  parameter int MAX_ADJ   = 24
) (
  input  logic              clk,
  input  logic              RESETn,
  input  logic              enable,
  input  logic              indicator,
  input  logic              done,
  input  logic [CNT_W-1:0]  win_len,
  input  logic [CNT_W-1:0]  settle_len,
  output logic [GAIN_W-1:0] gain,
  output logic              adjust,
  output logic              up_dn,
  output logic              sat,
  output logic              locked,
  output logic              timeout,
  output logic [1:0]        state_o
);

  localparam int ADJ_W  = $clog2(MAX_ADJ + 1);
  localparam int GOOD_W = $clog2(GOOD_WINS + 1);

  localparam logic [GAIN_W-1:0] GAIN_INIT_V = GAIN_W'(GAIN_INIT);
  localparam logic [GAIN_W-1:0] GAIN_MIN_V  = GAIN_W'(GAIN_MIN);
  localparam logic [GAIN_W-1:0] GAIN_MAX_V  = GAIN_W'(GAIN_MAX);
  localparam logic [ADJ_W-1:0]  MAX_ADJ_V   = ADJ_W'(MAX_ADJ);
  localparam logic [GOOD_W-1:0] GOOD_WINS_V = GOOD_W'(GOOD_WINS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DETECT = 2'b01,
    ST_SETTLE = 2'b10,
    ST_LOCK   = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [GAIN_W-1:0]  gain_q, gain_d;
  logic               adjust_q, adjust_d;
  logic               up_dn_q, up_dn_d;
  logic               sat_q, sat_d;
  logic               locked_q, locked_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
  logic [ADJ_W-1:0]   adj_cnt_q, adj_cnt_d;

  // Window evaluation terms. H includes the current sample, so it needs one
  // extra bit. The majority test 2*H > N uses one more bit again so that the
  // doubled count cannot overflow.
  logic [CNT_W:0]   h_sum;
  logic [CNT_W:0]   n_len;
  logic             win_last;
  logic             req_up;
  logic             req_dn;
  logic             at_clamp;
  logic [ADJ_W-1:0] adj_inc;
  logic [GOOD_W-1:0] good_inc;

  assign h_sum    = {1'b0, hi_cnt_q} + (CNT_W + 1)'(indicator);
  assign n_len    = {1'b0, win_len} + (CNT_W + 1)'(1);
  assign win_last = (win_cnt_q == win_len);
  assign req_up   = (h_sum == '0);
  assign req_dn   = !req_up && ({h_sum, 1'b0} > {1'b0, n_len});
  assign at_clamp = req_up ? (gain_q == GAIN_MAX_V) : (gain_q == GAIN_MIN_V);
  assign adj_inc  = adj_cnt_q + ADJ_W'(1);
  assign good_inc = good_cnt_q + GOOD_W'(1);

  // Next-state and next-output logic. Priority order is enable, then done,
  // then the normal state transitions.
  always_comb begin
    state_d      = state_q;
    gain_d       = gain_q;
    adjust_d     = 1'b0;
    up_dn_d      = up_dn_q;
    sat_d        = sat_q;
    timeout_d    = timeout_q;
    win_cnt_d    = win_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    settle_cnt_d = settle_cnt_q;
    good_cnt_d   = good_cnt_q;
    adj_cnt_d    = adj_cnt_q;

    if (!enable) begin
      state_d      = ST_IDLE;
      gain_d       = GAIN_INIT_V;
      sat_d        = 1'b0;
      timeout_d    = 1'b0;
      win_cnt_d    = '0;
      hi_cnt_d     = '0;
      settle_cnt_d = '0;
      good_cnt_d   = '0;
      adj_cnt_d    = '0;
    end else if (done && (state_q != ST_IDLE)) begin
      // Preamble found: freeze the gain where it is.
      state_d = ST_LOCK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_DETECT;
          gain_d       = GAIN_INIT_V;
          sat_d        = 1'b0;
          timeout_d    = 1'b0;
          win_cnt_d    = '0;
          hi_cnt_d     = '0;
          settle_cnt_d = '0;
          good_cnt_d   = '0;
          adj_cnt_d    = '0;
        end

        ST_DETECT: begin
          win_cnt_d = win_cnt_q + CNT_W'(1);
          hi_cnt_d  = hi_cnt_q + CNT_W'(indicator);
          if (win_last) begin
            win_cnt_d = '0;
            hi_cnt_d  = '0;
            if (req_up || req_dn) begin
              good_cnt_d = '0;
              if (at_clamp) begin
                // Requested step is beyond a clamp: hold and run another window.
                sat_d = 1'b1;
              end else begin
                gain_d    = req_up ? (gain_q + GAIN_W'(1)) : (gain_q - GAIN_W'(1));
                adjust_d  = 1'b1;
                up_dn_d   = req_up;
                sat_d     = 1'b0;
                adj_cnt_d = adj_inc;
                if (adj_inc == MAX_ADJ_V) begin
                  // Step budget exhausted: lock at once and skip the settle.
                  state_d   = ST_LOCK;
                  timeout_d = 1'b1;
                end else begin
                  state_d      = ST_SETTLE;
                  settle_cnt_d = '0;
                end
              end
            end else begin
              // Window is in band.
              sat_d      = 1'b0;
              good_cnt_d = good_inc;
              if (good_inc >= GOOD_WINS_V) begin
                state_d = ST_LOCK;
              end
            end
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_q == settle_len) begin
            state_d      = ST_DETECT;
            settle_cnt_d = '0;
            win_cnt_d    = '0;
            hi_cnt_d     = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + CNT_W'(1);
          end
        end

        ST_LOCK: begin
          state_d = ST_LOCK;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCK);
  end

  // State and output registers, cleared asynchronously by RESETn.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= ST_IDLE;
      gain_q       <= GAIN_INIT_V;
      adjust_q     <= 1'b0;
      up_dn_q      <= 1'b1;
      sat_q        <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      win_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      settle_cnt_q <= '0;
      good_cnt_q   <= '0;
      adj_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      gain_q       <= gain_d;
      adjust_q     <= adjust_d;
      up_dn_q      <= up_dn_d;
      sat_q        <= sat_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
      win_cnt_q    <= win_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      good_cnt_q   <= good_cnt_d;
      adj_cnt_q    <= adj_cnt_d;
    end
  end

  assign gain    = gain_q;
  assign adjust  = adjust_q;
  assign up_dn   = up_dn_q;
  assign sat     = sat_q;
  assign locked  = locked_q;
  assign timeout = timeout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_agc_gain_controller.sv
// tb_agc_gain_controller
// Directed scenarios for the AGC loop at default parameters. Inputs are driven
// and outputs sampled on the falling clock edge. Cycle c is the interval that
// follows the c-th rising edge after enable is raised.
module tb_agc_gain_controller;

  logic       clk = 1'b0;
  logic       RESETn;
  logic       enable;
  logic       indicator;
  logic       done;
  logic [3:0] win_len;
  logic [3:0] settle_len;
  logic [4:0] gain;
  logic       adjust;
  logic       up_dn;
  logic       sat;
  logic       locked;
  logic       timeout;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_DETECT = 2'b01;
  localparam logic [1:0] S_SETTLE = 2'b10;
  localparam logic [1:0] S_LOCK   = 2'b11;

  always #5 clk = ~clk;

  agc_gain_controller dut (
    .clk        (clk),
    .RESETn     (RESETn),
    .enable     (enable),
    .indicator  (indicator),
    .done       (done),
    .win_len    (win_len),
    .settle_len (settle_len),
    .gain       (gain),
    .adjust     (adjust),
    .up_dn      (up_dn),
    .sat        (sat),
    .locked     (locked),
    .timeout    (timeout),
    .state_o    (state_o)
  );

  // Drop enable and wait until the loop sits in IDLE at a falling edge.
  task automatic go_idle();
    enable = 1'b0; done = 1'b0; indicator = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    RESETn = 1'b0; enable = 1'b0; indicator = 1'b0; done = 1'b0;
    win_len = 4'd3; settle_len = 4'd1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({state_o, gain, adjust, up_dn, sat, locked, timeout} !== {S_IDLE, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: got state=%b gain=%0d adj=%b up=%b sat=%b lock=%b to=%b, want 00 16 0 1 0 0 0",
               state_o, gain, adjust, up_dn, sat, locked, timeout);
    end
    RESETn = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_first_step();
    logic [1:0] es;
    go_idle();
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) @(negedge clk);
      es = (c == 0) ? S_IDLE : (c <= 4) ? S_DETECT : (c <= 6) ? S_SETTLE : S_DETECT;
      n_cmp++;
      if (state_o !== es) begin
        n_err++; $display("FAIL first_step_state c=%0d: got %b want %b", c, state_o, es);
      end
      n_cmp++;
      if (gain !== ((c >= 5) ? 5'd17 : 5'd16)) begin
        n_err++; $display("FAIL first_step_gain c=%0d: got %0d want %0d", c, gain, (c >= 5) ? 17 : 16);
      end
      n_cmp++;
      if (adjust !== (c == 5)) begin
        n_err++; $display("FAIL first_step_adjust c=%0d: got %b want %b", c, adjust, (c == 5));
      end
      if (c == 5) begin
        n_cmp++;
        if (up_dn !== 1'b1) begin
          n_err++; $display("FAIL first_step_updn: got %b want 1", up_dn);
        end
      end
      if (c == 0) enable = 1'b1;
    end
    $display("test_first_step done");
  endtask

  task automatic test_min_lengths();
    go_idle();
    win_len = 4'd0; settle_len = 4'd0;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2 || c == 4) begin
        n_cmp++;
        if (state_o !== S_SETTLE || adjust !== 1'b1 || gain !== ((c == 2) ? 5'd17 : 5'd18)) begin
          n_err++; $display("FAIL min_len_step c=%0d: got state=%b adj=%b gain=%0d want 10 1 %0d",
                            c, state_o, adjust, gain, (c == 2) ? 17 : 18);
        end
      end
      if (c == 1 || c == 3) begin
        n_cmp++;
        if (state_o !== S_DETECT) begin
          n_err++; $display("FAIL min_len_detect c=%0d: got %b want 01", c, state_o);
        end
      end
      if (c == 0) enable = 1'b1;
    end
    win_len = 4'd3; settle_len = 4'd1;
    $display("test_min_lengths done");
  endtask

  task automatic test_step_down();
    int pulses = 0;
    go_idle();
    for (int c = 0; c <= 101; c++) begin
      logic exp_adj;
      if (c > 0) @(negedge clk);
      exp_adj = (c >= 5) && (c <= 95) && ((c - 5) % 6 == 0);
      if (adjust === 1'b1) pulses++;
      n_cmp++;
      if (adjust !== exp_adj) begin
        n_err++; $display("FAIL step_down_adjust c=%0d: got %b want %b", c, adjust, exp_adj);
      end
      if (exp_adj) begin
        n_cmp++;
        if (gain !== 5'(15 - (c - 5) / 6) || up_dn !== 1'b0 || sat !== 1'b0) begin
          n_err++; $display("FAIL step_down_gain c=%0d: got gain=%0d up=%b sat=%b want %0d 0 0",
                            c, gain, up_dn, sat, 15 - (c - 5) / 6);
        end
      end
      if (c == 101) begin
        n_cmp++;
        if (gain !== 5'd0 || sat !== 1'b1 || state_o !== S_DETECT) begin
          n_err++; $display("FAIL step_down_clamp: got gain=%0d sat=%b state=%b want 0 1 01", gain, sat, state_o);
        end
      end
      if (c == 0) begin enable = 1'b1; indicator = 1'b1; end
    end
    n_cmp++;
    if (pulses != 16) begin
      n_err++; $display("FAIL step_down_pulses: got %0d want 16", pulses);
    end
    go_idle();
    n_cmp++;
    if (gain !== 5'd16 || sat !== 1'b0 || state_o !== S_IDLE) begin
      n_err++; $display("FAIL idle_reload: got gain=%0d sat=%b state=%b want 16 0 00", gain, sat, state_o);
    end
    $display("test_step_down done");
  endtask

  task automatic test_inband_lock();
    go_idle();
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) @(negedge clk);
      n_cmp++;
      if (adjust !== 1'b0) begin
        n_err++; $display("FAIL inband_adjust c=%0d: got %b want 0", c, adjust);
      end
      if (c >= 1 && c <= 8) begin
        n_cmp++;
        if (state_o !== S_DETECT || locked !== 1'b0) begin
          n_err++; $display("FAIL inband_detect c=%0d: got state=%b lock=%b want 01 0", c, state_o, locked);
        end
      end
      if (c >= 9) begin
        n_cmp++;
        if (state_o !== S_LOCK || locked !== 1'b1 || gain !== 5'd16) begin
          n_err++; $display("FAIL inband_lock c=%0d: got state=%b lock=%b gain=%0d want 11 1 16",
                            c, state_o, locked, gain);
        end
      end
      if (c == 0) enable = 1'b1;
      indicator = (c >= 1) && ((c - 1) % 4 == 0);
    end
    $display("test_inband_lock done");
  endtask

  task automatic test_done();
    go_idle();
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 3) begin
        n_cmp++;
        if (state_o !== S_LOCK || gain !== 5'd16 || locked !== 1'b1) begin
          n_err++; $display("FAIL done_midwin c=%0d: got state=%b gain=%0d lock=%b want 11 16 1",
                            c, state_o, gain, locked);
        end
      end
      if (c == 0) enable = 1'b1;
      done = (c == 2);
    end
    go_idle();
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 1 && c <= 4) begin
        n_cmp++;
        if (state_o !== S_DETECT) begin
          n_err++; $display("FAIL done_idle_ignored c=%0d: got %b want 01", c, state_o);
        end
      end
      if (c >= 5) begin
        n_cmp++;
        if (state_o !== S_LOCK || gain !== 5'd16 || adjust !== 1'b0) begin
          n_err++; $display("FAIL done_eval c=%0d: got state=%b gain=%0d adj=%b want 11 16 0",
                            c, state_o, gain, adjust);
        end
      end
      if (c == 0) enable = 1'b1;
      done = (c == 0) || (c == 4);
    end
    $display("test_done done");
  endtask

  task automatic test_timeout();
    int pulses = 0;
    go_idle();
    for (int c = 0; c <= 146; c++) begin
      if (c > 0) @(negedge clk);
      if (adjust === 1'b1) pulses++;
      if (c == 137) begin
        n_cmp++;
        if (gain !== 5'd17 || state_o !== S_SETTLE || timeout !== 1'b0) begin
          n_err++; $display("FAIL timeout_step23: got gain=%0d state=%b to=%b want 17 10 0", gain, state_o, timeout);
        end
      end
      if (c == 143) begin
        n_cmp++;
        if (gain !== 5'd16 || state_o !== S_LOCK || locked !== 1'b1 || timeout !== 1'b1 || adjust !== 1'b1 || up_dn !== 1'b0) begin
          n_err++; $display("FAIL timeout_lock: got gain=%0d state=%b lock=%b to=%b adj=%b up=%b want 16 11 1 1 1 0",
                            gain, state_o, locked, timeout, adjust, up_dn);
        end
      end
      if (c == 144) begin
        n_cmp++;
        if (locked !== 1'b1 || timeout !== 1'b1 || adjust !== 1'b0) begin
          n_err++; $display("FAIL timeout_hold: got lock=%b to=%b adj=%b want 1 1 0", locked, timeout, adjust);
        end
      end
      if (c == 146) begin
        n_cmp++;
        if (state_o !== S_IDLE || gain !== 5'd16 || timeout !== 1'b0 || locked !== 1'b0) begin
          n_err++; $display("FAIL timeout_idle: got state=%b gain=%0d to=%b lock=%b want 00 16 0 0",
                            state_o, gain, timeout, locked);
        end
      end
      if (c == 0) enable = 1'b1;
      if (c == 145) enable = 1'b0;
      indicator = (c >= 1) && ((((c - 1) / 6) % 2) == 1);
    end
    n_cmp++;
    if (pulses != 24) begin
      n_err++; $display("FAIL timeout_pulses: got %0d want 24", pulses);
    end
    $display("test_timeout done");
  endtask

  task automatic test_async_reset();
    go_idle();
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) enable = 1'b1;
    end
    n_cmp++;
    if (state_o !== S_SETTLE || gain !== 5'd17) begin
      n_err++; $display("FAIL async_pre: got state=%b gain=%0d want 10 17", state_o, gain);
    end
    #2 RESETn = 1'b0;
    #1;
    n_cmp++;
    if ({state_o, gain, adjust, up_dn, sat, locked, timeout} !== {S_IDLE, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL async_reset: got state=%b gain=%0d adj=%b up=%b sat=%b lock=%b to=%b, want 00 16 0 1 0 0 0",
                        state_o, gain, adjust, up_dn, sat, locked, timeout);
    end
    enable = 1'b0;
    @(negedge clk);
    RESETn = 1'b1;
    @(negedge clk);
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_min_lengths();
    test_step_down();
    test_inband_lock();
    test_done();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
